// File: rtl/lock_entry_controller_pkg.sv
// Shared constants, key indices and state encoding for the digital lock controller.
package lock_pkg;

    localparam int DIGITS          = 4;
    localparam int CODE_LENGTH     = 4 * DIGITS;
    localparam int COUNTER_WIDTH   = $clog2(DIGITS);
    localparam int MAX_ATTEMPTS    = 3;
    localparam int LOCKOUT_CYCLES  = 16;
    localparam int MAX_DIGIT_VALUE = 9;

    localparam int KEY_ENTER  = 0;
    localparam int KEY_COMMIT = 1;
    localparam int KEY_CLEAR  = 2;

    typedef enum logic [1:0] {
        UNLOCKED,
        LOCKED,
        CHECK,
        LOCKOUT
    } lockState_e;

endpackage

// File: rtl/lock_entry_controller_if.sv
// Board-side bundle of the lock: key/switch inputs and actuator/display outputs.
interface lock_entry_controller_if #(
    parameter int DIGITS = 4
);
    localparam int CODE_LENGTH   = 4 * DIGITS;
    localparam int COUNTER_WIDTH = $clog2(DIGITS);

    logic [3:0]               key;
    logic [3:0]               digit;
    logic                     locked;
    logic                     lockout;
    logic [CODE_LENGTH-1:0]   pin_entry;
    logic [COUNTER_WIDTH:0]   entry_count;
    logic                     error;

    modport master (
        output key, digit,
        input  locked, lockout, pin_entry, entry_count, error
    );

    modport slave (
        input  key, digit,
        output locked, lockout, pin_entry, entry_count, error
    );

endinterface

// File: rtl/lock_entry_controller_edge.sv
// Rising-edge detector for the push keys; a key must be seen low after reset
// before it can produce an edge, so a key held through reset stays silent.
module key_edge_detect #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] level_i,
    output logic [WIDTH-1:0] rise_o
);

    logic [WIDTH-1:0] level_q;
    logic [WIDTH-1:0] armed_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            level_q <= '0;
            armed_q <= '0;
        end else begin
            level_q <= level_i;
            armed_q <= armed_q | ~level_i;
        end
    end

    assign rise_o = level_i & ~level_q & armed_q;

endmodule

// File: rtl/lock_entry_controller.sv
// Digital lock sequencer: PIN entry, code set/check, failure counting and timed lockout.
module lock_entry_controller
    import lock_pkg::*;
(
    input  logic                    clock,
    input  logic                    reset,
    lock_entry_controller_if.slave  bus
);

    localparam int COUNT_W = COUNTER_WIDTH + 1;
    localparam int FAIL_W  = $clog2(MAX_ATTEMPTS + 1);
    localparam int TIMER_W = $clog2(LOCKOUT_CYCLES);

    lockState_e               state_q, state_d;
    logic [CODE_LENGTH-1:0]   pinEntry_q, pinEntry_d;
    logic [COUNT_W-1:0]       entryCount_q, entryCount_d;
    logic [CODE_LENGTH-1:0]   storedCode_q, storedCode_d;
    logic [FAIL_W-1:0]        failCount_q, failCount_d;
    logic [TIMER_W-1:0]       timer_q, timer_d;
    logic                     error_q, error_d;
    logic                     locked_q;
    logic                     lockout_q;

    logic [2:0]               rise;
    logic                     entryFull;
    logic [FAIL_W-1:0]        failNext;

    // key[3] carries no function, so only the three live keys are edge-detected
    key_edge_detect #(.WIDTH(3)) u_keyEdge (
        .clock   (clock),
        .reset   (reset),
        .level_i (bus.key[2:0]),
        .rise_o  (rise)
    );

    always_comb begin
        state_d      = state_q;
        pinEntry_d   = pinEntry_q;
        entryCount_d = entryCount_q;
        storedCode_d = storedCode_q;
        failCount_d  = failCount_q;
        timer_d      = timer_q;
        error_d      = 1'b0;
        entryFull    = (entryCount_q == COUNT_W'(DIGITS));
        failNext     = failCount_q + FAIL_W'(1);

        case (state_q)
            UNLOCKED, LOCKED: begin
                if (rise[KEY_CLEAR]) begin
                    pinEntry_d   = '0;
                    entryCount_d = '0;
                end else if (rise[KEY_COMMIT]) begin
                    if (!entryFull) begin
                        error_d = 1'b1;
                    end else if (state_q == UNLOCKED) begin
                        storedCode_d = pinEntry_q;
                        pinEntry_d   = '0;
                        entryCount_d = '0;
                        state_d      = LOCKED;
                    end else begin
                        state_d = CHECK;
                    end
                end else if (rise[KEY_ENTER]) begin
                    if (bus.digit <= 4'(MAX_DIGIT_VALUE) && !entryFull) begin
                        pinEntry_d   = {pinEntry_q[CODE_LENGTH-5:0], bus.digit};
                        entryCount_d = entryCount_q + COUNT_W'(1);
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end
            CHECK: begin
                pinEntry_d   = '0;
                entryCount_d = '0;
                if (pinEntry_q == storedCode_q) begin
                    failCount_d = '0;
                    state_d     = UNLOCKED;
                end else begin
                    failCount_d = failNext;
                    error_d     = 1'b1;
                    if (failNext == FAIL_W'(MAX_ATTEMPTS)) begin
                        timer_d = '0;
                        state_d = LOCKOUT;
                    end else begin
                        state_d = LOCKED;
                    end
                end
            end
            LOCKOUT: begin
                pinEntry_d   = '0;
                entryCount_d = '0;
                if (timer_q == TIMER_W'(LOCKOUT_CYCLES - 1)) begin
                    timer_d     = '0;
                    failCount_d = '0;
                    state_d     = LOCKED;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end
            default: state_d = UNLOCKED;
        endcase
    end

    // locked/lockout are registered from the next state so they never see inputs combinationally
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= UNLOCKED;
            pinEntry_q   <= '0;
            entryCount_q <= '0;
            storedCode_q <= '0;
            failCount_q  <= '0;
            timer_q      <= '0;
            error_q      <= 1'b0;
            locked_q     <= 1'b0;
            lockout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            pinEntry_q   <= pinEntry_d;
            entryCount_q <= entryCount_d;
            storedCode_q <= storedCode_d;
            failCount_q  <= failCount_d;
            timer_q      <= timer_d;
            error_q      <= error_d;
            locked_q     <= (state_d != UNLOCKED);
            lockout_q    <= (state_d == LOCKOUT);
        end
    end

    assign bus.locked      = locked_q;
    assign bus.lockout     = lockout_q;
    assign bus.pin_entry   = pinEntry_q;
    assign bus.entry_count = entryCount_q;
    assign bus.error       = error_q;

endmodule

// File: tb/tb_lock_entry_controller.sv
// Scoreboard bench for lock_entry_controller: a behavioural lock model predicts
// the outputs after every clock and a monitor compares them on the falling edge.
module tb_lock_entry_controller;

    typedef struct packed {
        logic        locked;
        logic        lockout;
        logic [15:0] pin;
        logic [2:0]  count;
        logic        err;
    } expect_t;

    logic clock = 1'b0;
    logic resetIn;
    int   checkCount = 0;
    int   passCount  = 0;

    expect_t expQ[$];

    bit       mLocked;
    bit       mChecking;
    int       mLockoutLeft;
    int       mCode;
    int       mPin;
    int       mCount;
    int       mFails;
    bit       mErr;
    bit [3:0] mPrev;

    lock_entry_controller_if #(.DIGITS(4)) busIf ();

    lock_entry_controller dut (
        .clock (clock),
        .reset (resetIn),
        .bus   (busIf)
    );

    always #5 clock = ~clock;

    // Model reasons about the lock as plain numbers: a 4-digit value, a count,
    // a remaining-lockout budget and a pending-check flag.
    task automatic modelStep(input bit rst, input logic [3:0] k, input logic [3:0] d);
        bit [3:0] edges;
        expect_t  e;
        if (rst) begin
            mLocked = 0; mChecking = 0; mLockoutLeft = 0; mCode = 0;
            mPin = 0; mCount = 0; mFails = 0; mErr = 0; mPrev = 4'hF;
        end else begin
            edges = k & ~mPrev & 4'b0111;
            mPrev = k;
            mErr  = 0;
            if (mLockoutLeft > 0) begin
                mLockoutLeft--;
                if (mLockoutLeft == 0) mFails = 0;
            end else if (mChecking) begin
                mChecking = 0;
                if (mPin == mCode) begin
                    mFails  = 0;
                    mLocked = 0;
                end else begin
                    mFails++;
                    mErr = 1;
                    if (mFails == 3) mLockoutLeft = 16;
                end
                mPin = 0; mCount = 0;
            end else if (edges[2]) begin
                mPin = 0; mCount = 0;
            end else if (edges[1]) begin
                if (mCount < 4) mErr = 1;
                else if (!mLocked) begin
                    mCode = mPin; mPin = 0; mCount = 0; mLocked = 1;
                end else mChecking = 1;
            end else if (edges[0]) begin
                if (d <= 9 && mCount < 4) begin
                    mPin = ((mPin * 16) + int'(d)) % 65536;
                    mCount++;
                end else mErr = 1;
            end
        end
        e.locked  = mLocked;
        e.lockout = (mLockoutLeft > 0);
        e.pin     = 16'(mPin);
        e.count   = 3'(mCount);
        e.err     = mErr;
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input bit rst, input logic [3:0] k, input logic [3:0] d);
        resetIn     = rst;
        busIf.key   = k;
        busIf.digit = d;
        @(posedge clock);
        modelStep(rst, k, d);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic pressKey(input logic [3:0] k, input int d);
        applyStimulus(0, k, 4'(d));
        applyStimulus(0, 4'b0000, 4'(d));
    endtask

    task automatic enterCode(input int code);
        for (int i = 3; i >= 0; i--) pressKey(4'b0001, (code >> (4 * i)) & 15);
    endtask

    task automatic commitEntry();
        pressKey(4'b0010, 0);
        applyStimulus(0, 4'b0000, 4'd0);
    endtask

    initial begin
        expect_t e;
        forever begin
            @(negedge clock);
            if (expQ.size() > 0) begin
                e = expQ.pop_front();
                checkOutput("locked",      32'(busIf.locked),      32'(e.locked));
                checkOutput("lockout",     32'(busIf.lockout),     32'(e.lockout));
                checkOutput("pin_entry",   32'(busIf.pin_entry),   32'(e.pin));
                checkOutput("entry_count", 32'(busIf.entry_count), 32'(e.count));
                checkOutput("error",       32'(busIf.error),       32'(e.err));
            end
        end
    end

    initial begin
        int r;
        applyStimulus(1, 4'b0000, 4'd0);
        applyStimulus(1, 4'b0000, 4'd0);

        enterCode(16'h1234); commitEntry();
        enterCode(16'h1234); commitEntry();
        enterCode(16'h1234); commitEntry();
        for (int i = 0; i < 3; i++) begin
            enterCode(16'h9999); commitEntry();
        end
        pressKey(4'b0001, 5);
        pressKey(4'b0010, 0);
        for (int i = 0; i < 14; i++) applyStimulus(0, 4'b0000, 4'd0);
        enterCode(16'h9999); commitEntry();
        enterCode(16'h1234); commitEntry();

        pressKey(4'b0001, 1); pressKey(4'b0001, 2); commitEntry();
        pressKey(4'b0001, 12);
        pressKey(4'b0100, 0);
        enterCode(16'h5678); pressKey(4'b0001, 9);
        pressKey(4'b0100, 0);
        pressKey(4'b0101, 7);

        applyStimulus(1, 4'b0001, 4'd3);
        applyStimulus(1, 4'b0001, 4'd3);
        for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0001, 4'd3);
        pressKey(4'b0000, 0);
        pressKey(4'b0001, 3);

        applyStimulus(1, 4'b0000, 4'd0);
        enterCode(16'h1111); commitEntry();
        for (int i = 0; i < 3; i++) begin
            enterCode(16'h2222); commitEntry();
        end
        for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0000, 4'd0);
        applyStimulus(1, 4'b0000, 4'd0);
        for (int i = 0; i < 3; i++) applyStimulus(0, 4'b0000, 4'd0);

        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 99);
            if (r < 3) begin
                applyStimulus(1, 4'($urandom_range(0, 15)), 4'd0);
            end else if (r < 15 && mLocked && !mChecking && mLockoutLeft == 0) begin
                pressKey(4'b0100, 0);
                enterCode(mCode);
                commitEntry();
            end else begin
                applyStimulus(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 12)));
            end
        end

        applyStimulus(0, 4'b0000, 4'd0);
        @(negedge clock);
        #1;
        if (expQ.size() != 0) begin
            checkCount++;
            $display("[TB] FAIL drain: %0d expectations left, expected 0", expQ.size());
        end
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
